// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the timing generator and
// the tile/board renderers (which use the V_ values for their v_cnt
// window offsets).
//   H_/V_ visible, porch and sync lengths, H_TOTAL/V_TOTAL frame totals,
//   SYNC_ACTIVE (asserted sync level), RGB_W (pixel width),
//   timing_t (active/hs/vs bundle carried down the delay line),
//   in_window() half-open range test on 12-bit counters.
package vga_pkg;

    localparam int CNT_W = 12;
    localparam int RGB_W = 12;

    localparam logic [CNT_W-1:0] H_VISIBLE = 12'd640;
    localparam logic [CNT_W-1:0] H_FRONT   = 12'd16;
    localparam logic [CNT_W-1:0] H_SYNC    = 12'd96;
    localparam logic [CNT_W-1:0] H_BACK    = 12'd48;
    localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [CNT_W-1:0] V_VISIBLE = 12'd480;
    localparam logic [CNT_W-1:0] V_FRONT   = 12'd10;
    localparam logic [CNT_W-1:0] V_SYNC    = 12'd2;
    localparam logic [CNT_W-1:0] V_BACK    = 12'd33;
    localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Raw timing decoded from the counters; all-zero means blank, no sync.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } timing_t;

    // True while lo <= cnt < hi (unsigned).
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register shift line with asynchronous
// active-low clear to RESET_VAL. DEPTH=0 is a plain wire.
//   clk_i   clock
//   rst_ni  asynchronous active-low clear
//   data_i  WIDTH-bit input
//   data_o  data_i delayed by DEPTH clocks
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_ni;
            assign data_o = data_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter source and VGA output stage.
//   clk          system clock
//   rst          asynchronous active-low reset
//   h_cnt/v_cnt  raster counters, held for CLK_DIV clocks per pixel
//   pix_tick     high on the last clock of each pixel period
//   line_start   high on the first clock of each h_cnt==0 pixel
//   frame_start  line_start qualified with v_cnt==0
//   pix_data     RGB444 from the renderers, PIPE_DELAY clocks behind counters
//   vga_rgb      pixel to the pins, forced 0 outside the visible area
//   hsync/vsync  sync at SYNC_ACTIVE polarity, aligned with vga_rgb
// Sync/blank are delayed PIPE_DELAY clocks and then registered together
// with pix_data, so pins lag the counters by PIPE_DELAY+1 clocks.
module vga_timing_gen #(
    parameter logic [11:0] H_VISIBLE   = vga_pkg::H_VISIBLE,
    parameter logic [11:0] H_FRONT     = vga_pkg::H_FRONT,
    parameter logic [11:0] H_SYNC      = vga_pkg::H_SYNC,
    parameter logic [11:0] H_BACK      = vga_pkg::H_BACK,
    parameter logic [11:0] V_VISIBLE   = vga_pkg::V_VISIBLE,
    parameter logic [11:0] V_FRONT     = vga_pkg::V_FRONT,
    parameter logic [11:0] V_SYNC      = vga_pkg::V_SYNC,
    parameter logic [11:0] V_BACK      = vga_pkg::V_BACK,
    parameter logic        SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
    parameter int          CLK_DIV     = 4,
    parameter int          PIPE_DELAY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start,
    input  logic [11:0] pix_data,
    output logic [11:0] vga_rgb,
    output logic        hsync,
    output logic        vsync
);
    import vga_pkg::*;

    localparam logic [11:0] HTOT     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [11:0] VTOT     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] HS_START = H_VISIBLE + H_FRONT;
    localparam logic [11:0] HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam logic [11:0] VS_START = V_VISIBLE + V_FRONT;
    localparam logic [11:0] VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]       div_cnt_q, div_cnt_d;
    logic [11:0]      h_cnt_q, h_cnt_d;
    logic [11:0]      v_cnt_q, v_cnt_d;
    logic             tick;
    timing_t          raw_s, dly_s;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == HTOT - 12'd1) begin
                h_cnt_d = 12'd0;
                v_cnt_d = (v_cnt_q == VTOT - 12'd1) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= 4'd0;
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    // Pulses are gated with rst so they read 0 while reset is held (with
    // CLK_DIV=1 the reset state already satisfies the tick/start compares).
    assign pix_tick    = rst & tick;
    assign line_start  = rst & (div_cnt_q == 4'd0) & (h_cnt_q == 12'd0);
    assign frame_start = line_start & (v_cnt_q == 12'd0);

    always_comb begin
        raw_s.active = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
        raw_s.hs     = in_window(h_cnt_q, HS_START, HS_END);
        raw_s.vs     = in_window(v_cnt_q, VS_START, VS_END);
    end

    vga_delay_line #(
        .WIDTH     ($bits(timing_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (3'b000)
    ) u_delay (
        .clk_i  (clk),
        .rst_ni (rst),
        .data_i (raw_s),
        .data_o (dly_s)
    );

    always_comb begin
        rgb_d   = dly_s.active ? pix_data : '0;
        hsync_d = dly_s.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = dly_s.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q   <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign h_cnt   = h_cnt_q;
    assign v_cnt   = v_cnt_q;
    assign vga_rgb = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances on one clock/reset.
//   dut_a: reduced 25x13 raster, CLK_DIV=4, PIPE_DELAY=2 (full frames, wraps)
//   dut_b: same raster, CLK_DIV=1, PIPE_DELAY=0 (1-clk latency variant)
//   dut_c: 640x480 timing, CLK_DIV=1, PIPE_DELAY=2 (hsync window, (799,10))
// The expected raster is computed from the clock count since reset release
// by division, independent of the counter implementation.
module tb_vga_timing_gen;

    localparam int SH_V = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_V = 6,  SV_F = 2, SV_S = 2, SV_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pix_a, pix_b, pix_c;
    logic [11:0] h_a, v_a, rgb_a, h_b, v_b, rgb_b, h_c, v_c, rgb_c;
    logic        pt_a, ls_a, fs_a, hs_a, vs_a;
    logic        pt_b, ls_b, fs_b, hs_b, vs_b;
    logic        pt_c, ls_c, fs_c, hs_c, vs_c;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int n        = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(12'd16), .H_FRONT(12'd2), .H_SYNC(12'd4), .H_BACK(12'd3),
        .V_VISIBLE(12'd6),  .V_FRONT(12'd2), .V_SYNC(12'd2), .V_BACK(12'd3),
        .SYNC_ACTIVE(1'b0), .CLK_DIV(4), .PIPE_DELAY(2)
    ) dut_a (
        .clk(clk), .rst(rst), .h_cnt(h_a), .v_cnt(v_a), .pix_tick(pt_a),
        .line_start(ls_a), .frame_start(fs_a), .pix_data(pix_a),
        .vga_rgb(rgb_a), .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(12'd16), .H_FRONT(12'd2), .H_SYNC(12'd4), .H_BACK(12'd3),
        .V_VISIBLE(12'd6),  .V_FRONT(12'd2), .V_SYNC(12'd2), .V_BACK(12'd3),
        .SYNC_ACTIVE(1'b0), .CLK_DIV(1), .PIPE_DELAY(0)
    ) dut_b (
        .clk(clk), .rst(rst), .h_cnt(h_b), .v_cnt(v_b), .pix_tick(pt_b),
        .line_start(ls_b), .frame_start(fs_b), .pix_data(pix_b),
        .vga_rgb(rgb_b), .hsync(hs_b), .vsync(vs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .PIPE_DELAY(2)
    ) dut_c (
        .clk(clk), .rst(rst), .h_cnt(h_c), .v_cnt(v_c), .pix_tick(pt_c),
        .line_start(ls_c), .frame_start(fs_c), .pix_data(pix_c),
        .vga_rgb(rgb_c), .hsync(hs_c), .vsync(vs_c)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic [11:0] pat(input int h, input int v);
        logic [11:0] hh, vv;
        hh = 12'(h);
        vv = 12'(v);
        return {hh[5:0], vv[5:0]};
    endfunction

    // Renderer stand-in: pattern of the raster position pd clocks ago.
    function automatic logic [11:0] pix_at(input int cyc, input int cd, input int ht,
                                           input int vt, input int pd);
        int k;
        k = cyc - pd;
        if (k < 0) return 12'h000;
        return pat((k / cd) % ht, ((k / cd) / ht) % vt);
    endfunction

    task automatic drive_pix();
        pix_a = pix_at(n, 4, 25, 13, 2);
        pix_b = pix_at(n, 1, 25, 13, 0);
        pix_c = pix_at(n, 1, 800, 525, 2);
    endtask

    task automatic check_inst(input string nm, input int cd, input int pd,
                              input int hv, input int hf, input int hs, input int hb,
                              input int vv, input int vf, input int vs, input int vb,
                              input logic [11:0] h_o, input logic [11:0] v_o,
                              input logic [11:0] rgb_o, input logic pt_o,
                              input logic ls_o, input logic fs_o,
                              input logic hsync_o, input logic vsync_o);
        int ht, vt, dv, h, v, m, hm, vm;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_ls;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        dv = n % cd;
        h  = (n / cd) % ht;
        v  = ((n / cd) / ht) % vt;
        e_ls = (dv == 0) && (h == 0);
        chk({nm, " h_cnt"}, h_o, 12'(h));
        chk({nm, " v_cnt"}, v_o, 12'(v));
        chk({nm, " pix_tick"}, {11'd0, pt_o}, {11'd0, dv == cd - 1});
        chk({nm, " line_start"}, {11'd0, ls_o}, {11'd0, e_ls});
        chk({nm, " frame_start"}, {11'd0, fs_o}, {11'd0, e_ls && (v == 0)});
        e_rgb = 12'h000;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        m = n - pd - 1;
        if (m >= 0) begin
            hm = (m / cd) % ht;
            vm = ((m / cd) / ht) % vt;
            if (hm >= hv + hf && hm < hv + hf + hs) e_hs = 1'b0;
            if (vm >= vv + vf && vm < vv + vf + vs) e_vs = 1'b0;
            if (hm < hv && vm < vv) e_rgb = pat(hm, vm);
        end
        chk({nm, " vga_rgb"}, rgb_o, e_rgb);
        chk({nm, " hsync"}, {11'd0, hsync_o}, {11'd0, e_hs});
        chk({nm, " vsync"}, {11'd0, vsync_o}, {11'd0, e_vs});
    endtask

    task automatic check_all();
        check_inst("a", 4, 2, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B,
                   h_a, v_a, rgb_a, pt_a, ls_a, fs_a, hs_a, vs_a);
        check_inst("b", 1, 0, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B,
                   h_b, v_b, rgb_b, pt_b, ls_b, fs_b, hs_b, vs_b);
        check_inst("c", 1, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                   h_c, v_c, rgb_c, pt_c, ls_c, fs_c, hs_c, vs_c);
    endtask

    task automatic check_reset(input string nm, input logic [11:0] h_o, input logic [11:0] v_o,
                               input logic [11:0] rgb_o, input logic pt_o, input logic ls_o,
                               input logic fs_o, input logic hsync_o, input logic vsync_o);
        chk({nm, " rst h_cnt"}, h_o, 12'd0);
        chk({nm, " rst v_cnt"}, v_o, 12'd0);
        chk({nm, " rst vga_rgb"}, rgb_o, 12'h000);
        chk({nm, " rst pulses"}, {9'd0, pt_o, ls_o, fs_o}, 12'd0);
        chk({nm, " rst syncs"}, {10'd0, hsync_o, vsync_o}, 12'd3);
    endtask

    task automatic check_reset_all();
        check_reset("a", h_a, v_a, rgb_a, pt_a, ls_a, fs_a, hs_a, vs_a);
        check_reset("b", h_b, v_b, rgb_b, pt_b, ls_b, fs_b, hs_b, vs_b);
        check_reset("c", h_c, v_c, rgb_c, pt_c, ls_c, fs_c, hs_c, vs_c);
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        #1;
        drive_pix();
        check_all();
    endtask

    // True when dut_a's pins should show both syncs asserted at cycle cyc.
    function automatic logic a_both_sync(input int cyc);
        int m, hm, vm;
        m = cyc - 3;
        if (m < 0) return 1'b0;
        hm = (m / 4) % 25;
        vm = ((m / 4) / 25) % 13;
        return (hm >= 18 && hm < 22) && (vm >= 8 && vm < 10);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int fs_cnt_a, last_fs_a, prev_fs_a, ls_cnt_a, vs_low_a, hs_low_c;
        logic found;
        fs_cnt_a = 0; last_fs_a = 0; prev_fs_a = 0;
        ls_cnt_a = 0; vs_low_a = 0; hs_low_c = 0;
        pix_a = 12'hFFF; pix_b = 12'hFFF; pix_c = 12'hFFF;

        // Reset held: everything idle, syncs inactive.
        repeat (2) @(posedge clk);
        #1;
        check_reset_all();

        // Release; the first start pulses appear on this same clock.
        rst = 1'b1;
        n = 0;
        drive_pix();
        #1;
        check_all();
        chk("a first frame_start", {11'd0, fs_a}, 12'd1);

        for (int i = 0; i <= 8900; i++) begin
            if (i > 0) step();
            if (ls_a && n < 1300) ls_cnt_a++;
            if (!vs_a && n < 1300) vs_low_a++;
            if (!hs_c && n < 800) hs_low_c++;
            if (fs_a) begin
                fs_cnt_a++;
                prev_fs_a = last_fs_a;
                last_fs_a = n;
            end
            if (n == 1299) begin
                chk("a h before wrap", h_a, 12'd24);
                chk("a v before wrap", v_a, 12'd12);
            end
            if (n == 1300) begin
                chk("a h after wrap", h_a, 12'd0);
                chk("a v after wrap", v_a, 12'd0);
                chk("a frame_start at wrap", {11'd0, fs_a}, 12'd1);
            end
            if (n == 1301) chk("a frame_start one clk", {11'd0, fs_a}, 12'd0);
            if (n == 658) chk("c hsync before window", {11'd0, hs_c}, 12'd1);
            if (n == 659) chk("c hsync first low", {11'd0, hs_c}, 12'd0);
            if (n == 754) chk("c hsync last low", {11'd0, hs_c}, 12'd0);
            if (n == 755) chk("c hsync released", {11'd0, hs_c}, 12'd1);
            if (n == 8799) begin
                chk("c h at 799,10", h_c, 12'd799);
                chk("c v at 799,10", v_c, 12'd10);
            end
            if (n == 8800) begin
                chk("c h after 799,10", h_c, 12'd0);
                chk("c v after 799,10", v_c, 12'd11);
            end
        end

        chk("a frame_start count", 12'(fs_cnt_a), 12'd7);
        chk("a frame interval", 12'(last_fs_a - prev_fs_a), 12'd1300);
        chk("a line_start per frame", 12'(ls_cnt_a), 12'd13);
        chk("a vsync low clks", 12'(vs_low_a), 12'd200);
        chk("c hsync low clks", 12'(hs_low_c), 12'd96);

        // Advance into dut_a's combined hsync+vsync window, then reset mid-frame.
        found = a_both_sync(n);
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            found = a_both_sync(n);
        end
        chk("a sync window reached", {11'd0, found}, 12'd1);
        chk("a syncs asserted pre-reset", {10'd0, hs_a, vs_a}, 12'd0);

        #1;
        rst = 1'b0;
        pix_a = 12'hFFF; pix_b = 12'hFFF; pix_c = 12'hFFF;
        #1;
        check_reset_all();
        repeat (3) @(posedge clk);
        #1;
        check_reset_all();

        rst = 1'b1;
        n = 0;
        drive_pix();
        #1;
        check_all();
        for (int i = 0; i < 1400; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-counter interface: generates the h_cnt/v_cnt raster counters that the tile and board renderers consume, and returns their 12-bit pixel data to the VGA pins.
- Divides the system clock to the pixel rate and produces hsync/vsync.
- Delays sync and blanking by a fixed pipeline depth so they line up with the renderers' registered vga_data.
- Sits at top level, between the renderers and the board VGA connector.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync
- CLK_DIV, 4, clk cycles per pixel; legal range 1..16
- PIPE_DELAY, 2, clk-cycle latency of the downstream renderers; legal range 0..8

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- h_cnt  out  12  horizontal pixel counter, 0..H_TOTAL-1
- v_cnt  out  12  vertical line counter, 0..V_TOTAL-1
- pix_tick  out  1  one-clk pulse on the last clk of each pixel period
- line_start  out  1  one-clk pulse when h_cnt becomes 0
- frame_start  out  1  one-clk pulse when h_cnt and v_cnt both become 0
- pix_data  in  12  RGB444 from renderers, valid PIPE_DELAY clks after the counters
- vga_rgb  out  12  RGB444 to the pins, blanked outside the visible area
- hsync  out  1  horizontal sync, aligned with vga_rgb
- vsync  out  1  vertical sync, aligned with vga_rgb

Behaviour:
- Frame totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). All compares are 12-bit unsigned.
- Reset (rst=0, asynchronous):
  - div_cnt, h_cnt, v_cnt = 0
  - pix_tick, line_start, frame_start = 0
  - vga_rgb = 12'h000
  - hsync = vsync = ~SYNC_ACTIVE
  - all delay-line stages cleared to the blank/inactive values
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div_cnt == CLK_DIV-1), combinational from the register.
  - CLK_DIV=1 makes pix_tick constant 1 after reset.
- Counters: update only on clk edges where pix_tick=1.
  - h_cnt == H_TOTAL-1: h_cnt <= 0; v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1.
  - Otherwise h_cnt <= h_cnt+1 and v_cnt holds.
  - Counters are held stable for exactly CLK_DIV clks.
- Pulses:
  - line_start is high for the first clk of the h_cnt==0 pixel period.
  - frame_start is the same, qualified with v_cnt==0.
  - After reset release, the first line_start/frame_start occurs on the first clk with rst=1.
- Raw timing, decoded from the registered counters:
  - active_raw = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE
  - hs_raw asserted while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_raw asserted while V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491); vsync asserts over whole lines
- Alignment:
  - active_raw, hs_raw and vs_raw pass through a PIPE_DELAY-stage clk shift register.
  - Then one output register: vga_rgb <= active_d ? pix_data : 12'h000; hsync/vsync <= delayed values at SYNC_ACTIVE polarity.
  - End-to-end latency, counter change to pins, is PIPE_DELAY+1 clks.
  - PIPE_DELAY=0 means no shift stages, output register only.
- Boundaries:
  - Simultaneous h and v wrap at (799,524) goes to (0,0) in one tick.
  - pix_data is ignored (forced 0) throughout blanking and sync.
  - Reset asserted mid-frame clears the delay line immediately, so no stale sync pulse is emitted after release.
  - There is no other input-dependent state.

Decomposition:
- Shared package vga_pkg holds the 640x480@60 timing constants (H_/V_ porch and sync values, H_TOTAL, V_TOTAL), SYNC_ACTIVE, and RGB_W=12. The renderers reuse these for their v_cnt window offsets.
- One natural sub-module: vga_delay_line (parameter WIDTH, DEPTH; async active-low clear to a RESET_VAL parameter), used for the 3-bit active/hs/vs bundle.

Test Plan:
- Reset, then run one full frame with CLK_DIV=4 -> exactly 800*525*4 = 1,680,000 clks between frame_start pulses; 525 line_start pulses per frame; h_cnt stable for 4 clks each.
- Counter wrap -> at the tick after (799,524) the counters read (0,0) and frame_start=1 for one clk; at (799,10) the next values are (0,11).
- Sync windows, PIPE_DELAY=2 -> hsync is low exactly 96*4 clks per line, starting 3 clks after h_cnt becomes 656; vsync is low for exactly 2 lines starting 3 clks after v_cnt becomes 490.
- Blanking, pix_data=12'hFFF constant -> vga_rgb=12'hFFF only for the 640x480 region (shifted 3 clks), 12'h000 at h_cnt 640..799 and v_cnt 480..524.
- Alignment with a counter-derived pattern, pix_data = {h_cnt[5:0], v_cnt[5:0]} delayed 2 clks -> vga_rgb matches the expected pattern cycle-exactly; PIPE_DELAY=0 variant checks 1-clk latency.
- Mid-frame reset at (700,491) with syncs asserted -> outputs go inactive and vga_rgb=0 in the same cycle; after release counters restart at (0,0), and no sync asserts before h_cnt reaches 656 plus the latency.
